// File: rtl/screen_note_sequencer.sv
// rtl/screen_note_sequencer.sv - turns note events into 4-byte UART display messages
// Frames are handed to the transmitter one at a time over a valid/ready handshake.
module screen_note_sequencer #(
  parameter logic [7:0] CMD_PREFIX = 8'hFE,
  parameter logic [7:0] CURSOR_CMD = 8'h80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       note_valid,
  input  logic [3:0] note_code,
  input  logic       tx_ready,
  output logic [9:0] frame_out,
  output logic       frame_valid,
  output logic       busy,
  output logic       overwrite
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] byte_idx;
  logic [3:0] active_code;
  logic [3:0] pending_code;
  logic       pending_valid;

  logic strobe_ok;
  logic last_exit;
  logic direct_take;

  function automatic logic [7:0] note_letter(input logic [3:0] code);
    logic [7:0] ch;
    case (code)
      4'd0, 4'd1:   ch = 8'h43;  // C
      4'd2, 4'd3:   ch = 8'h44;  // D
      4'd4:         ch = 8'h45;  // E
      4'd5, 4'd6:   ch = 8'h46;  // F
      4'd7, 4'd8:   ch = 8'h47;  // G
      4'd9, 4'd10:  ch = 8'h41;  // A
      4'd11:        ch = 8'h42;  // B
      default:      ch = 8'h3F;
    endcase
    return ch;
  endfunction

  function automatic logic is_sharp(input logic [3:0] code);
    return (code == 4'd1) || (code == 4'd3) || (code == 4'd6) ||
           (code == 4'd8) || (code == 4'd10);
  endfunction

  function automatic logic [9:0] msg_frame(input logic [1:0] idx, input logic [3:0] code);
    logic [7:0] b;
    case (idx)
      2'd0:    b = CMD_PREFIX;
      2'd1:    b = CURSOR_CMD;
      2'd2:    b = note_letter(code);
      default: b = is_sharp(code) ? 8'h23 : 8'h20;
    endcase
    return {1'b1, b, 1'b0};
  endfunction

  assign strobe_ok   = note_valid && (note_code < 4'd12);
  assign last_exit   = (state == WAIT_IDLE) && tx_ready && (byte_idx == 2'd3);
  // With nothing pending, a strobe on the final exit edge becomes the next message.
  assign direct_take = strobe_ok && last_exit && !pending_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      byte_idx      <= 2'd0;
      active_code   <= 4'd0;
      pending_code  <= 4'd0;
      pending_valid <= 1'b0;
      frame_out     <= 10'h3FF;
      frame_valid   <= 1'b0;
      busy          <= 1'b0;
      overwrite     <= 1'b0;
    end else begin
      overwrite <= 1'b0;

      case (state)
        IDLE: begin
          if (strobe_ok) begin
            active_code <= note_code;
            byte_idx    <= 2'd0;
            frame_out   <= msg_frame(2'd0, note_code);
            frame_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= SEND;
          end
        end

        SEND: begin
          if (tx_ready) begin
            frame_valid <= 1'b0;
            state       <= WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          if (!tx_ready) begin
            state <= WAIT_IDLE;
          end
        end

        WAIT_IDLE: begin
          if (tx_ready) begin
            if (byte_idx != 2'd3) begin
              byte_idx    <= byte_idx + 2'd1;
              frame_out   <= msg_frame(byte_idx + 2'd1, active_code);
              frame_valid <= 1'b1;
              state       <= SEND;
            end else if (pending_valid) begin
              active_code   <= pending_code;
              pending_valid <= 1'b0;
              byte_idx      <= 2'd0;
              frame_out     <= msg_frame(2'd0, pending_code);
              frame_valid   <= 1'b1;
              state         <= SEND;
            end else if (direct_take) begin
              active_code <= note_code;
              byte_idx    <= 2'd0;
              frame_out   <= msg_frame(2'd0, note_code);
              frame_valid <= 1'b1;
              state       <= SEND;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: begin
          state       <= IDLE;
          frame_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase

      // Strobes during a message go to the one-deep buffer; this overrides the
      // pending clear above when the buffer is drained and refilled on one edge.
      if (strobe_ok && (state != IDLE) && !direct_take) begin
        pending_code  <= note_code;
        pending_valid <= 1'b1;
        if (pending_valid && !last_exit) begin
          overwrite <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_screen_note_sequencer.sv
// tb/tb_screen_note_sequencer.sv - directed self-checking bench for screen_note_sequencer
module tb_screen_note_sequencer;

  logic       clk;
  logic       reset_n;
  logic       note_valid;
  logic [3:0] note_code;
  logic       tx_ready;
  logic [9:0] frame_out;
  logic       frame_valid;
  logic       busy;
  logic       overwrite;

  logic       tx_idle;
  logic       tx_hold;
  logic [9:0] log_mem [0:255];
  int         log_n;
  int         ov_count;

  int checks;
  int failures;

  screen_note_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .note_valid  (note_valid),
    .note_code   (note_code),
    .tx_ready    (tx_ready),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .busy        (busy),
    .overwrite   (overwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_ready = tx_idle & ~tx_hold;

  // Transmitter model: takes a frame, goes busy for 3 cycles, then idles again.
  initial begin
    tx_idle = 1'b1;
    log_n   = 0;
    forever begin
      @(negedge clk);
      if (frame_valid && tx_ready && reset_n) begin
        log_mem[log_n[7:0]] = frame_out;
        log_n = log_n + 1;
        @(posedge clk);
        #1 tx_idle = 1'b0;
        repeat (3) @(posedge clk);
        #1 tx_idle = 1'b1;
      end
    end
  end

  initial begin
    ov_count = 0;
    forever begin
      @(negedge clk);
      if (overwrite) ov_count = ov_count + 1;
    end
  end

  task automatic strobe(input logic [3:0] code);
    @(posedge clk);
    #1 note_valid = 1'b1;
    note_code = code;
    @(posedge clk);
    #1 note_valid = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy && tx_idle) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (frame_out !== 10'h3FF) begin failures++; $display("FAIL reset_frame_out got=%h want=3ff", frame_out); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid got=%b want=0", frame_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (overwrite !== 1'b0) begin failures++; $display("FAIL reset_overwrite got=%b want=0", overwrite); end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_message_e;
    logic ok;
    int base;
    logic [9:0] exp [0:3];
    exp[0] = 10'h3FC; exp[1] = 10'h300; exp[2] = 10'h28A; exp[3] = 10'h240;
    base = log_n;
    strobe(4'd4);
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL e_latency frame_valid got=%b want=1", frame_valid); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL e_timeout busy got=%b want=0", busy); end
    checks++; if (log_n - base !== 4) begin failures++; $display("FAIL e_count got=%0d want=4", log_n - base); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_mem[base + k] !== exp[k]) begin
        failures++; $display("FAIL e_frame%0d got=%h want=%h", k, log_mem[base + k], exp[k]);
      end
    end
  endtask

  task automatic test_sharp;
    logic ok;
    int base;
    base = log_n;
    strobe(4'd1);
    wait_idle(ok);
    checks++; if (!ok || (log_n - base !== 4)) begin failures++; $display("FAIL csharp_count got=%0d want=4", log_n - base); end
    checks++; if (log_mem[base + 2] !== 10'h286) begin failures++; $display("FAIL csharp_letter got=%h want=286", log_mem[base + 2]); end
    checks++; if (log_mem[base + 3] !== 10'h246) begin failures++; $display("FAIL csharp_accidental got=%h want=246", log_mem[base + 3]); end
  endtask

  task automatic test_invalid;
    int base;
    logic seen;
    base = log_n;
    seen = 1'b0;
    strobe(4'd13);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_valid || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL invalid_activity got=%b want=0", seen); end
    checks++; if (log_n - base !== 0) begin failures++; $display("FAIL invalid_frames got=%0d want=0", log_n - base); end
  endtask

  task automatic test_overwrite;
    logic ok;
    logic saw_g;
    int base;
    int ov_base;
    base = log_n;
    ov_base = ov_count;
    saw_g = 1'b0;
    strobe(4'd4);
    strobe(4'd7);
    strobe(4'd9);
    wait_idle(ok);
    checks++; if (ov_count - ov_base !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d want=1", ov_count - ov_base); end
    checks++; if (!ok || (log_n - base !== 8)) begin failures++; $display("FAIL ovr_count got=%0d want=8", log_n - base); end
    checks++; if (log_mem[base + 6] !== 10'h282) begin failures++; $display("FAIL ovr_letter got=%h want=282", log_mem[base + 6]); end
    for (int k = 0; k < log_n - base; k++) begin
      if (log_mem[base + k] === 10'h28E) saw_g = 1'b1;
    end
    checks++; if (saw_g !== 1'b0) begin failures++; $display("FAIL ovr_g_sent got=%b want=0", saw_g); end
  endtask

  task automatic test_stall;
    logic ok;
    logic bad;
    int base;
    logic [9:0] exp [0:3];
    exp[0] = 10'h3FC; exp[1] = 10'h300; exp[2] = 10'h288; exp[3] = 10'h240;
    base = log_n;
    bad = 1'b0;
    tx_hold = 1'b1;
    strobe(4'd2);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frame_valid !== 1'b1 || frame_out !== 10'h3FC) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL stall_hold got=%b want=0 (fv=%b fo=%h)", bad, frame_valid, frame_out); end
    @(posedge clk);
    #1 tx_hold = 1'b0;
    wait_idle(ok);
    checks++; if (!ok || (log_n - base !== 4)) begin failures++; $display("FAIL stall_count got=%0d want=4", log_n - base); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_mem[base + k] !== exp[k]) begin
        failures++; $display("FAIL stall_frame%0d got=%h want=%h", k, log_mem[base + k], exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic ok;
    int base;
    base = log_n;
    strobe(4'd4);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (log_n - base >= 2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got=%0d want=2", log_n - base); end
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL rmid_frame_valid got=%b want=0", frame_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", busy); end
    wait_idle(ok);
    base = log_n;
    strobe(4'd4);
    wait_idle(ok);
    checks++; if (!ok || (log_n - base !== 4)) begin failures++; $display("FAIL rmid_count got=%0d want=4", log_n - base); end
    checks++; if (log_mem[base] !== 10'h3FC) begin failures++; $display("FAIL rmid_restart got=%h want=3fc", log_mem[base]); end
  endtask

  task automatic test_back_to_back;
    logic ok;
    int base;
    int ov_base;
    base = log_n;
    ov_base = ov_count;
    strobe(4'd4);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((log_n - base == 4) && tx_ready) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d want=4", log_n - base); end
    note_valid = 1'b1;
    note_code  = 4'd9;
    @(posedge clk);
    #1 note_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || frame_valid !== 1'b1) begin failures++; $display("FAIL b2b_direct busy=%b fv=%b want=1", busy, frame_valid); end
    wait_idle(ok);
    checks++; if (!ok || (log_n - base !== 8)) begin failures++; $display("FAIL b2b_count got=%0d want=8", log_n - base); end
    checks++; if (log_mem[base + 6] !== 10'h282) begin failures++; $display("FAIL b2b_letter got=%h want=282", log_mem[base + 6]); end
    checks++; if (ov_count - ov_base !== 0) begin failures++; $display("FAIL b2b_overwrite got=%0d want=0", ov_count - ov_base); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    note_valid = 1'b0;
    note_code  = 4'd0;
    tx_hold    = 1'b0;
    test_reset;
    test_message_e;
    test_sharp;
    test_invalid;
    test_overwrite;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
